// File: rtl/alu_muldiv.sv
// ALU with iterative unsigned multiply (shift-add) and optional restoring divide.
// The divider is built only when the macro ALU_MULDIV_DIV_EN is defined.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk__i,
  input  logic             rst_n__i,
  input  logic             start__i,
  input  logic [3:0]       op__i,
  input  logic [WIDTH-1:0] dataA__i,
  input  logic [WIDTH-1:0] dataB__i,
  output logic [WIDTH-1:0] result__o,
  output logic [WIDTH-1:0] resultHi__o,
  output logic             valid__o,
  output logic             zero__o,
  output logic             busy__o,
  output logic             illegal__o,
  output logic             divZero__o
);

  localparam logic [3:0] OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011, OP_NOR  = 4'b0100, OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110, OP_SLT  = 4'b0111, OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001, OP_SRA  = 4'b1010, OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t            r_state, w_stateNext;
  logic [CNTW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_lo, r_hi, r_b;
  logic [WIDTH-1:0]  r_result, r_resultHi;
  logic              r_illegal;

  logic              w_accept, w_isMul, w_isDiv, w_aluIllegal;
  logic [WIDTH-1:0]  w_aluResult, w_stepLo, w_stepHi, w_mulHi, w_mulLo;
  logic [WIDTH:0]    w_mulSum;
  logic [CNTW-2:0]   w_shamt;

  assign w_accept = start__i && (r_state == IDLE);
  assign w_isMul  = (op__i == OP_MULU);
  assign w_shamt  = dataB__i[CNTW-2:0];

  always_comb begin
    w_aluResult  = '0;
    w_aluIllegal = 1'b0;
    case (op__i)
      OP_AND:  w_aluResult = dataA__i & dataB__i;
      OP_OR:   w_aluResult = dataA__i | dataB__i;
      OP_ADD:  w_aluResult = dataA__i + dataB__i;
      OP_XOR:  w_aluResult = dataA__i ^ dataB__i;
      OP_NOR:  w_aluResult = ~(dataA__i | dataB__i);
      OP_SLL:  w_aluResult = dataA__i << w_shamt;
      OP_SUB:  w_aluResult = dataA__i - dataB__i;
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(dataA__i) < $signed(dataB__i))};
      OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (dataA__i < dataB__i)};
      OP_SRL:  w_aluResult = dataA__i >> w_shamt;
      OP_SRA:  w_aluResult = $signed(dataA__i) >>> w_shamt;
      OP_MULU: w_aluResult = '0;
`ifdef ALU_MULDIV_DIV_EN
      OP_DIVU: w_aluResult = '0;
`endif
      default: w_aluIllegal = 1'b1;
    endcase
  end

  // Multiplier step: conditionally add B into the high half, then shift {carry,hi,lo} right.
  assign w_mulSum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mulHi  = w_mulSum[WIDTH:1];
  assign w_mulLo  = {w_mulSum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_MULDIV_DIV_EN
  logic             r_isDiv, r_divZeroPend, r_divZero;
  logic [WIDTH:0]   w_divShift, w_divDiff;
  logic             w_divOk;

  // Restoring step: the dividend shifts into the remainder MSB-first; quotient bits fill r_lo.
  // A zero divisor always "succeeds", giving all-ones quotient and remainder equal to A.
  assign w_isDiv    = (op__i == OP_DIVU);
  assign w_divShift = {r_hi, r_lo[WIDTH-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_b};
  assign w_divOk    = (w_divShift >= {1'b0, r_b});
  assign w_stepHi   = r_isDiv ? (w_divOk ? w_divDiff[WIDTH-1:0] : w_divShift[WIDTH-1:0]) : w_mulHi;
  assign w_stepLo   = r_isDiv ? {r_lo[WIDTH-2:0], w_divOk} : w_mulLo;
  assign divZero__o = r_divZero;

  always_ff @(posedge clk__i) begin
    if (!rst_n__i) begin
      r_isDiv       <= 1'b0;
      r_divZeroPend <= 1'b0;
      r_divZero     <= 1'b0;
    end else if (w_accept) begin
      r_isDiv       <= w_isDiv;
      r_divZeroPend <= w_isDiv && (dataB__i == '0);
      if (!w_isMul && !w_isDiv) r_divZero <= 1'b0;
    end else if (r_state == ITER && r_cnt == CNTW'(1)) begin
      r_divZero     <= r_divZeroPend;
    end
  end
`else
  assign w_isDiv    = 1'b0;
  assign w_stepHi   = w_mulHi;
  assign w_stepLo   = w_mulLo;
  assign divZero__o = 1'b0;
`endif

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = (w_isMul || w_isDiv) ? ITER : DONE;
      ITER:    if (r_cnt == CNTW'(1)) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Result registers change only on the edge entering DONE, so they hold between pulses.
  always_ff @(posedge clk__i) begin
    if (!rst_n__i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_resultHi <= '0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_lo  <= dataA__i;
        r_hi  <= '0;
        r_b   <= dataB__i;
        r_cnt <= CNTW'(WIDTH);
        if (!w_isMul && !w_isDiv) begin
          r_result   <= w_aluResult;
          r_resultHi <= '0;
          r_illegal  <= w_aluIllegal;
        end
      end else if (r_state == ITER) begin
        r_lo  <= w_stepLo;
        r_hi  <= w_stepHi;
        r_cnt <= r_cnt - CNTW'(1);
        if (r_cnt == CNTW'(1)) begin
          r_result   <= w_stepLo;
          r_resultHi <= w_stepHi;
          r_illegal  <= 1'b0;
        end
      end
    end
  end

  assign result__o   = r_result;
  assign resultHi__o = r_resultHi;
  assign illegal__o  = r_illegal;
  assign zero__o     = (r_result == '0);
  assign valid__o    = (r_state == DONE);
  assign busy__o     = (r_state != IDLE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed vectors, random ops against
// an arithmetic reference model, and a mid-operation reset.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [3:0]  op;
  logic [31:0] dataA, dataB;
  logic [31:0] result, resultHi;
  logic        valid, zero, busy, illegal, divZero;

  int errors = 0;
  int checks = 0;
  logic [31:0] obsRes, obsHi;
  logic        obsIll, obsDz;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ill;
    logic        dz;
    int          lat;
  } exp_t;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk__i(clk), .rst_n__i(rstN), .start__i(start), .op__i(op),
    .dataA__i(dataA), .dataB__i(dataB),
    .result__o(result), .resultHi__o(resultHi), .valid__o(valid),
    .zero__o(zero), .busy__o(busy), .illegal__o(illegal), .divZero__o(divZero)
  );

  always #5 clk = ~clk;

  function automatic exp_t refModel(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.lo = '0; e.hi = '0; e.ill = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (o)
      4'd0:  e.lo = a & b;
      4'd1:  e.lo = a | b;
      4'd2:  e.lo = a + b;
      4'd3:  e.lo = a ^ b;
      4'd4:  e.lo = ~(a | b);
      4'd5:  e.lo = a << b[4:0];
      4'd6:  e.lo = a - b;
      4'd7:  e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  e.lo = (a < b) ? 32'd1 : 32'd0;
      4'd9:  e.lo = a >> b[4:0];
      4'd10: e.lo = $signed(a) >>> b[4:0];
      4'd12: begin
        p = 64'(a) * 64'(b);
        e.lo = p[31:0]; e.hi = p[63:32]; e.lat = 33;
      end
`ifdef ALU_MULDIV_DIV_EN
      4'd13: begin
        e.lat = 33;
        if (b == 0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one op (idle DUT assumed), optionally poke a competing start and new operands mid-op.
  task automatic applyStimulus(input string tag, input logic [3:0] o, input logic [31:0] a,
                               input logic [31:0] b, input int injectAt);
    exp_t e;
    int n;
    e = refModel(o, a, b);
    start = 1'b1; op = o; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!valid && n < 100) begin
      if (n == injectAt) begin
        start = 1'b1; op = 4'd2; dataA = 32'h1234; dataB = 32'h4321;
      end else begin
        start = 1'b0; dataA = ~a; dataB = ~b;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    checkOutput({tag, ".latency"}, 64'(n), 64'(e.lat));
    checkOutput({tag, ".result"}, 64'(result), 64'(e.lo));
    checkOutput({tag, ".resultHi"}, 64'(resultHi), 64'(e.hi));
    checkOutput({tag, ".illegal"}, 64'(illegal), 64'(e.ill));
    checkOutput({tag, ".divZero"}, 64'(divZero), 64'(e.dz));
    checkOutput({tag, ".zero"}, 64'(zero), 64'(e.lo == 0));
    checkOutput({tag, ".busyDone"}, 64'(busy), 64'd1);
    obsRes = result; obsHi = resultHi; obsIll = illegal; obsDz = divZero;
    @(posedge clk); #1;
    checkOutput({tag, ".validPulse"}, 64'(valid), 64'd0);
    checkOutput({tag, ".busyIdle"}, 64'(busy), 64'd0);
    checkOutput({tag, ".hold"}, 64'(result), 64'(e.lo));
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; op = '0; dataA = '0; dataB = '0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset.valid", 64'(valid), 64'd0);
    checkOutput("reset.busy", 64'(busy), 64'd0);
    checkOutput("reset.zero", 64'(zero), 64'd1);
    checkOutput("reset.result", 64'(result), 64'd0);
    checkOutput("reset.flags", 64'({illegal, divZero}), 64'd0);
    rstN = 1'b1;

    applyStimulus("addWrap", 4'd2, 32'hFFFF_FFFF, 32'd1, -1);
    checkOutput("addWrap.literal", 64'(obsRes), 64'd0);
    applyStimulus("slt", 4'd7, 32'hFFFF_FFFF, 32'd1, -1);
    checkOutput("slt.literal", 64'(obsRes), 64'd1);
    applyStimulus("sltu", 4'd8, 32'hFFFF_FFFF, 32'd1, -1);
    checkOutput("sltu.literal", 64'(obsRes), 64'd0);
    applyStimulus("sra", 4'd10, 32'h8000_0000, 32'd4, -1);
    checkOutput("sra.literal", 64'(obsRes), 64'hF800_0000);
    applyStimulus("srl", 4'd9, 32'h8000_0000, 32'h0000_0024, -1);
    applyStimulus("sll", 4'd5, 32'h0000_00F1, 32'd31, -1);
    applyStimulus("sub", 4'd6, 32'd3, 32'd5, -1);
    applyStimulus("nor", 4'd4, 32'h0F0F_0000, 32'h0000_00F0, -1);
    applyStimulus("mulMax", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    checkOutput("mulMax.hiLiteral", 64'(obsHi), 64'hFFFF_FFFE);
    checkOutput("mulMax.loLiteral", 64'(obsRes), 64'd1);
    applyStimulus("div100by7", 4'd13, 32'd100, 32'd7, 3);
`ifdef ALU_MULDIV_DIV_EN
    checkOutput("div100by7.quot", 64'(obsRes), 64'd14);
    checkOutput("div100by7.rem", 64'(obsHi), 64'd2);
`else
    checkOutput("div100by7.illegal", 64'(obsIll), 64'd1);
`endif
    applyStimulus("div5by0", 4'd13, 32'd5, 32'd0, -1);
`ifdef ALU_MULDIV_DIV_EN
    checkOutput("div5by0.quot", 64'(obsRes), 64'hFFFF_FFFF);
    checkOutput("div5by0.rem", 64'(obsHi), 64'd5);
    checkOutput("div5by0.dz", 64'(obsDz), 64'd1);
`else
    checkOutput("div5by0.illegal", 64'(obsIll), 64'd1);
    checkOutput("div5by0.dz", 64'(obsDz), 64'd0);
`endif
    applyStimulus("illegal15", 4'd15, 32'hDEAD_BEEF, 32'h1, -1);
    checkOutput("illegal15.flag", 64'(obsIll), 64'd1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]  rOp;
      logic [31:0] rA, rB;
      rOp = 4'($urandom_range(0, 15));
      rA  = $urandom;
      rB  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      applyStimulus($sformatf("rand%0d_op%0d", i, rOp), rOp, rA, rB, int'($urandom_range(2, 20)));
    end

    // Leave a nonzero result, then abort a multiply with reset at its tenth ITER cycle.
    applyStimulus("preReset", 4'd2, 32'd1, 32'd2, -1);
    start = 1'b1; op = 4'd12; dataA = 32'hFFFF_FFFF; dataB = 32'h7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    rstN = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort.valid", 64'(valid), 64'd0);
    checkOutput("abort.busy", 64'(busy), 64'd0);
    checkOutput("abort.result", 64'({resultHi, result}), 64'd0);
    checkOutput("abort.zero", 64'(zero), 64'd1);
    checkOutput("abort.flags", 64'({illegal, divZero}), 64'd0);
    rstN = 1'b1;
    applyStimulus("postReset", 4'd2, 32'd2, 32'd3, -1);
    checkOutput("postReset.literal", 64'(obsRes), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
